// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the instruction-fetch path
//   fetch_state_t : fetch controller states (BOOT, RUN, HALT)
//   IMEM_ADDR_W   : instruction memory word-address width
//   INST_W        : instruction width
//   RESET_PC      : byte PC loaded on entry to RUN
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int          IMEM_ADDR_W = 10;
  localparam int          INST_W      = 32;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - boot stream, memory port and decode handshake bundle
//   boot_*     : program-image load stream (valid/ready, addr, data, done pulse)
//   mem_*      : single write port and combinational read port of the memory
//   redirect_* : branch/jump redirect from execute
//   inst_*     : one-entry output register to decode (valid/ready)
//   fetch_fault: sticky fault flag
//   master     : the fetch controller side; slave: the environment side
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              boot_valid;
  logic              boot_ready;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_data;
  logic              boot_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [31:0]       inst_pc;
  logic              fetch_fault;

  modport master (
    input  boot_valid, boot_addr, boot_data, boot_done,
    input  mem_rdata, redirect_valid, redirect_pc, inst_ready,
    output boot_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    output inst_valid, inst_data, inst_pc, fetch_fault
  );

  modport slave (
    output boot_valid, boot_addr, boot_data, boot_done,
    output mem_rdata, redirect_valid, redirect_pc, inst_ready,
    input  boot_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    input  inst_valid, inst_data, inst_pc, fetch_fault
  );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction-fetch controller owning the instruction memory ports
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : imem_fetch_ctrl_if.master (boot stream, memory ports, redirect, decode handshake)
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = cpu_pkg::IMEM_ADDR_W,
  parameter int          DATA_W   = cpu_pkg::INST_W,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_fetch_ctrl_if.master    bus
);

  import cpu_pkg::*;

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]        state, state_n;
  logic [31:0]       pc, pc_n;
  logic              iv, iv_n;
  logic [DATA_W-1:0] idata, idata_n;
  logic [31:0]       ipc, ipc_n;
  logic              fault, fault_n;
  logic              pc_legal;

  // Word aligned and inside the 4*2^ADDR_W byte window; anything above faults
  // long before the 32-bit PC could wrap.
  assign pc_legal = (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    iv_n      = iv;
    idata_n   = idata;
    ipc_n     = ipc;
    fault_n   = fault;
    bus.boot_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_waddr  = bus.boot_addr;
    bus.mem_wdata  = bus.boot_data;
    bus.mem_re     = 1'b0;
    bus.mem_raddr  = pc[ADDR_W+1:2];

    case (state)
      ST_BOOT: begin
        bus.boot_ready = 1'b1;
        bus.mem_we     = bus.boot_valid;
        if (bus.boot_done) begin
          state_n = ST_RUN;
          pc_n    = RESET_PC;
        end
      end

      ST_RUN: begin
        if (bus.redirect_valid) begin
          // Flush wins even over a same-cycle accept by decode.
          iv_n = 1'b0;
          pc_n = bus.redirect_pc;
        end else if (!iv || bus.inst_ready) begin
          if (pc_legal) begin
            bus.mem_re = 1'b1;
            idata_n    = bus.mem_rdata;
            ipc_n      = pc;
            iv_n       = 1'b1;
            pc_n       = pc + 32'd4;
          end else begin
            state_n = ST_HALT;
            iv_n    = 1'b0;
            fault_n = 1'b1;
          end
        end
      end

      default: begin
        // HALT (and the unused encoding) is terminal until reset.
        iv_n    = 1'b0;
        fault_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      iv    <= 1'b0;
      idata <= '0;
      ipc   <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      iv    <= iv_n;
      idata <= idata_n;
      ipc   <= ipc_n;
      fault <= fault_n;
    end
  end

  assign bus.inst_valid  = iv;
  assign bus.inst_data   = idata;
  assign bus.inst_pc     = ipc;
  assign bus.fetch_fault = fault;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] mem [0:1023];

  imem_fetch_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  imem_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_raddr];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] d, input logic [31:0] p);
    expect_eq({tag, ".valid"}, {31'd0, bus.inst_valid}, 32'd1);
    expect_eq({tag, ".data"},  bus.inst_data, d);
    expect_eq({tag, ".pc"},    bus.inst_pc, p);
  endtask

  task automatic boot_wr(input logic [9:0] a, input logic [31:0] d, input logic done);
    bus.boot_valid = 1'b1;
    bus.boot_addr  = a;
    bus.boot_data  = d;
    bus.boot_done  = done;
    #1;
    expect_eq("boot.we",    {31'd0, bus.mem_we}, 32'd1);
    expect_eq("boot.waddr", {22'd0, bus.mem_waddr}, {22'd0, a});
    expect_eq("boot.re",    {31'd0, bus.mem_re}, 32'd0);
    step();
    bus.boot_valid = 1'b0;
    bus.boot_done  = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    #1;
    expect_eq("redir.re", {31'd0, bus.mem_re}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    expect_eq("redir.flush", {31'd0, bus.inst_valid}, 32'd0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    expect_eq({tag, ".valid"}, {31'd0, bus.inst_valid}, 32'd0);
    expect_eq({tag, ".data"},  bus.inst_data, 32'd0);
    expect_eq({tag, ".pc"},    bus.inst_pc, 32'd0);
    expect_eq({tag, ".fault"}, {31'd0, bus.fetch_fault}, 32'd0);
    expect_eq({tag, ".bready"}, {31'd0, bus.boot_ready}, 32'd1);
    expect_eq({tag, ".re"},    {31'd0, bus.mem_re}, 32'd0);
  endtask

  task automatic reboot_empty();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.boot_done = 1'b1;
    step();
    bus.boot_done = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst                = 1'b0;
    bus.boot_valid     = 1'b0;
    bus.boot_addr      = '0;
    bus.boot_data      = '0;
    bus.boot_done      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;

    #3;
    expect_reset_outputs("reset");
    step();
    step();
    rst = 1'b1;

    // Image load; a redirect held through BOOT must have no effect.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    boot_wr(10'd0,     32'h11, 1'b0);
    boot_wr(10'd1,     32'h22, 1'b0);
    boot_wr(10'd2,     32'h33, 1'b0);
    boot_wr(10'd3,     32'h44, 1'b0);
    boot_wr(10'd8,     32'hAA, 1'b0);
    boot_wr(10'h3FE,   32'hE0, 1'b0);
    boot_wr(10'h3FF,   32'hF0, 1'b0);
    boot_wr(10'd5,     32'h55, 1'b1);
    bus.redirect_valid = 1'b0;
    expect_eq("boot.word5", mem[5], 32'h55);

    // Cycle N+1: fetch issues, nothing valid yet.
    bus.inst_ready = 1'b1;
    #1;
    expect_eq("run.valid0", {31'd0, bus.inst_valid}, 32'd0);
    expect_eq("run.re",     {31'd0, bus.mem_re}, 32'd1);
    expect_eq("run.raddr",  {22'd0, bus.mem_raddr}, 32'd0);
    expect_eq("run.bready", {31'd0, bus.boot_ready}, 32'd0);
    step();
    expect_inst("s0", 32'h11, 32'h0);
    step();
    expect_inst("s1", 32'h22, 32'h4);

    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_eq("stall.re", {31'd0, bus.mem_re}, 32'd0);
      step();
      expect_inst("stall", 32'h22, 32'h4);
    end
    bus.inst_ready = 1'b1;
    step();
    expect_inst("s2", 32'h33, 32'h8);
    step();
    expect_inst("s3", 32'h44, 32'hC);

    // Hold 0x22 again, then redirect to 0x20 while decode is ready.
    redirect(32'h4);
    bus.inst_ready = 1'b0;
    step();
    expect_inst("hold22", 32'h22, 32'h4);
    bus.inst_ready = 1'b1;
    redirect(32'h20);
    step();
    expect_inst("tgt", 32'hAA, 32'h20);

    // Asynchronous reset mid-stream, no clock edge in between.
    #2;
    rst = 1'b0;
    #1;
    expect_reset_outputs("midrst");
    step();
    rst = 1'b1;
    bus.boot_done = 1'b1;
    step();
    bus.boot_done = 1'b0;
    step();
    expect_inst("keep", 32'h11, 32'h0);

    // Run off the end of memory.
    redirect(32'hFF8);
    step();
    expect_inst("end0", 32'hE0, 32'hFF8);
    step();
    expect_inst("end1", 32'hF0, 32'hFFC);
    #1;
    expect_eq("end.re", {31'd0, bus.mem_re}, 32'd0);
    step();
    expect_eq("end.fault", {31'd0, bus.fetch_fault}, 32'd1);
    expect_eq("end.valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    expect_eq("halt.fault",  {31'd0, bus.fetch_fault}, 32'd1);
    expect_eq("halt.bready", {31'd0, bus.boot_ready}, 32'd0);
    expect_eq("halt.re",     {31'd0, bus.mem_re}, 32'd0);

    // Misaligned redirect target.
    reboot_empty();
    redirect(32'h6);
    #1;
    expect_eq("mis.re", {31'd0, bus.mem_re}, 32'd0);
    step();
    expect_eq("mis.fault", {31'd0, bus.fetch_fault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_eq("mis.valid", {31'd0, bus.inst_valid}, 32'd0);
      expect_eq("mis.sticky", {31'd0, bus.fetch_fault}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller that owns the single port pair of the 1024-word instruction memory. After reset it accepts a program image from a boot-load stream and writes it into memory. It then switches to run mode, sequencing sequential fetches from a program counter. A one-entry output register with valid/ready handshake feeds decode; branch redirects and address faults are handled here.

## Interface
- ADDR_W, 10, word-address width of instruction memory (depth 2^ADDR_W)
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, byte PC loaded on entry to RUN

- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- boot_valid  input  1  boot word present
- boot_ready  output  1  controller accepts boot word
- boot_addr  input  ADDR_W  boot word address
- boot_data  input  DATA_W  boot word
- boot_done  input  1  end of image (single-cycle pulse)
- mem_we  output  1  memory write enable
- mem_waddr  output  ADDR_W  memory write address
- mem_wdata  output  DATA_W  memory write data
- mem_re  output  1  memory read enable
- mem_raddr  output  ADDR_W  memory read address
- mem_rdata  input  DATA_W  memory read data, combinational from mem_raddr
- redirect_valid  input  1  branch/jump redirect
- redirect_pc  input  32  redirect target, byte address
- inst_valid  output  1  inst_data/inst_pc valid
- inst_ready  input  1  decode accepts instruction
- inst_data  output  DATA_W  fetched instruction
- inst_pc  output  32  byte PC of inst_data
- fetch_fault  output  1  sticky fault flag

## Operation
- States: BOOT, RUN, HALT. Reset → BOOT.
- BOOT:
  - boot_ready=1.
  - mem_we=boot_valid, mem_waddr=boot_addr, mem_wdata=boot_data.
  - mem_re=0. Redirects are ignored.
  - boot_done → RUN, pc←RESET_PC. If boot_valid and boot_done are high in the same cycle, the write is performed and the transition still occurs.
- RUN:
  - boot_ready=0, mem_we=0.
  - Fetch condition: (!inst_valid || inst_ready) && !redirect_valid && pc legal.
  - On fetch: mem_re=1, mem_raddr=pc[ADDR_W+1:2]; output register ← {mem_rdata, pc}, inst_valid←1, pc←pc+4.
  - If inst_valid && inst_ready and no fetch occurs, inst_valid←0.
- Redirect (RUN only, priority over fetch):
  - inst_valid←0 (flush; the held instruction is discarded even if inst_ready=1 that cycle).
  - pc←redirect_pc. No fetch occurs in the redirect cycle.
- Legal pc: pc[1:0]==0 and pc < 4·2^ADDR_W.
- In RUN, an illegal pc where a fetch would occur → HALT.
  - In HALT: fetch_fault=1, inst_valid=0, mem_re=0, mem_we=0, boot_ready=0.
  - Only reset leaves HALT.
- PC arithmetic is 32-bit and wraps modulo 2^32. Running off the end of memory faults before any wrap matters.
- mem_rdata is sampled only in the cycle mem_re=1.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0. Combinational outputs follow the BOOT decode (boot_ready=1).
- Boot write: zero latency; memory is written on the edge where boot_valid=1.
- First inst_valid: 1 cycle after the boot_done edge. Cycle N+1 issues the fetch; inst_valid is high from N+2, where N is the boot_done cycle.
- Throughput: 1 instruction/cycle while inst_ready=1.
- Stall: inst_data and inst_pc are held stable while inst_valid && !inst_ready.
- Redirect at cycle R: inst_valid=0 at R+1, and the target instruction is valid at R+2.
- Fault: detected in the cycle the fetch would issue. fetch_fault=1 from the next edge; the held instruction is dropped.
- Asserting rst mid-operation immediately forces reset values; memory contents are untouched.

## Structure
- Shared package `cpu_pkg`: fetch_state_t enum {BOOT, RUN, HALT}, IMEM_ADDR_W=10, INST_W=32, RESET_PC constant.
- Single flat module; no sub-module. The output register and PC are local registers, and the next-state and fetch decode are one combinational block.

## Test plan
- Boot then run: write words 0..3 = 0x11,0x22,0x33,0x44, pulse boot_done, inst_ready=1 → inst_valid from boot_done+2, stream 0x11@pc0, 0x22@pc4, 0x33@pc8, 0x44@pc12.
- Backpressure: inst_ready=0 for 3 cycles while holding 0x22@pc4 → output stable, mem_re=0. Release → 0x33@pc8 next cycle, no loss or duplication.
- Redirect: redirect_valid with redirect_pc=0x20 (word 8 = 0xAA) while 0x22 is held → inst_valid=0 next cycle, then 0xAA@pc0x20. 0x22 is never accepted.
- Faults: redirect_pc=0x6 → fetch_fault=1 and inst_valid=0 permanently. Separately, sequential fetch past pc=0xFFC → fault at pc=0x1000.
- Simultaneous boot_valid (addr 5, data 0x55) and boot_done → word 5 written, RUN entered. Redirect_valid asserted during BOOT has no effect.
- Reset mid-stream: drop rst while inst_valid=1 → all outputs return to reset values immediately. After re-boot with boot_done only, memory still holds the previous image.
